// File: rtl/xps2_rx_pkg.sv
// Shared definitions for the PS/2 receiver: bus width, register offsets, status bit map, FSM states.
// Optional feature macro: PS2_PARITY_CHK_EN (odd-parity checking of received frames).
`ifndef DATA_W
`define DATA_W 16
`endif

package xps2_rx_pkg;

    localparam int DATA_W = `DATA_W;

    localparam logic [31:0] PS2_BASE      = 32'h0000_4000;
    localparam logic        PS2_DATA_OFFS = 1'b0;
    localparam logic        PS2_STAT_OFFS = 1'b1;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_PARITY  = 3;
    localparam int ST_FRAME   = 4;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // True when eight data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/xps2_rx_if.sv
// Register-bus port of the PS/2 receiver: select, write enable, one-bit offset, write/read data.
interface xps2_rx_if;
    logic                 sel;
    logic                 we;
    logic                 addr;
    logic [`DATA_W-1:0]   data_in;
    logic [`DATA_W-1:0]   data_out;

    modport master (output sel, output we, output addr, output data_in, input data_out);
    modport slave  (input sel, input we, input addr, input data_in, output data_out);
endinterface

// File: rtl/xps2_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is dropped unless a pop happens in the same cycle.
module xps2_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    always_comb begin
        do_pop_s  = pop & (count_r != CW'(0));
        do_push_s = push & ((count_r != CW'(FIFO_DEPTH)) | do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = (count_r == CW'(FIFO_DEPTH));
    assign empty    = (count_r == CW'(0));
    assign count    = count_r;
endmodule

// File: rtl/xps2_rx.sv
// PS/2 device-to-host receiver with byte FIFO and DATA/STATUS register interface.
// Define PS2_PARITY_CHK_EN to discard frames with bad odd parity and report parity_err.
module xps2_rx
    import xps2_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    xps2_rx_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             clk_meta_r, clk_sync_r, clk_prev_r;
    logic             data_meta_r, data_sync_r;
    logic             fall_s;
    ps2_state_e       state_r, state_nxt_s;
    logic [2:0]       bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]       shift_r, shift_nxt_s;
    logic             parity_r, parity_nxt_s;
    logic [TW-1:0]    tmo_cnt_r, tmo_cnt_nxt_s;
    logic             timeout_s;
    logic             par_bad_s;
    logic             push_nxt_s, push_r;
    logic             set_fe_s, set_pe_s, set_ov_s;
    logic             overrun_r, parity_err_r, frame_err_r;
    logic             rd_data_s, rd_stat_s, wr_stat_s, pop_s;
    logic [2:0]       clr_s;
    logic [7:0]       head_s;
    logic             full_s, empty_s;
    logic [CW-1:0]    count_s;
    logic [DATA_W-1:0] stat_s;
    logic [DATA_W-1:0] data_out_r;

    // Two-flop synchronisers plus a history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            clk_prev_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            clk_prev_r  <= clk_sync_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    assign fall_s = clk_prev_r & ~clk_sync_r;

`ifdef PS2_PARITY_CHK_EN
    assign par_bad_s = ~odd_parity_ok(shift_r, parity_r);
`else
    logic unused_parity_s;
    assign unused_parity_s = parity_r;
    assign par_bad_s       = 1'b0;
`endif

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            tmo_cnt_r <= TW'(0);
            push_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            parity_r  <= parity_nxt_s;
            tmo_cnt_r <= tmo_cnt_nxt_s;
            push_r    <= push_nxt_s;
        end
    end

    // Next-state logic: edge-driven frame walk with an inactivity abort.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        parity_nxt_s  = parity_r;
        push_nxt_s    = 1'b0;
        set_fe_s      = 1'b0;
        set_pe_s      = 1'b0;

        if ((state_r == IDLE) || fall_s) begin
            tmo_cnt_nxt_s = TW'(0);
        end else begin
            tmo_cnt_nxt_s = tmo_cnt_r + TW'(1);
        end
        timeout_s = (state_r != IDLE) && !fall_s && (tmo_cnt_r == TW'(TIMEOUT_CYC - 1));

        if (timeout_s) begin
            state_nxt_s   = IDLE;
            bit_cnt_nxt_s = 3'd0;
        end else if (fall_s) begin
            case (state_r)
                IDLE: begin
                    bit_cnt_nxt_s = 3'd0;
                    if (!data_sync_r) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                DATA: begin
                    shift_nxt_s   = {data_sync_r, shift_r[7:1]};
                    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = PARITY;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end
                PARITY: begin
                    parity_nxt_s = data_sync_r;
                    state_nxt_s  = STOP;
                end
                STOP: begin
                    state_nxt_s = IDLE;
                    if (!data_sync_r) begin
                        set_fe_s = 1'b1;
                    end else if (par_bad_s) begin
                        set_pe_s = 1'b1;
                    end else begin
                        push_nxt_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s   = IDLE;
                    bit_cnt_nxt_s = 3'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    xps2_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_r),
        .push_data (shift_r),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Bus decode and status word assembly.
    always_comb begin
        rd_data_s = bus.sel & ~bus.we & (bus.addr == PS2_DATA_OFFS);
        rd_stat_s = bus.sel & ~bus.we & (bus.addr == PS2_STAT_OFFS);
        wr_stat_s = bus.sel &  bus.we & (bus.addr == PS2_STAT_OFFS);
        pop_s     = rd_data_s & ~empty_s;
        set_ov_s  = push_r & full_s & ~pop_s;
        if (wr_stat_s) begin
            clr_s = bus.data_in[4:2];
        end else begin
            clr_s = 3'b000;
        end
        stat_s                          = '0;
        stat_s[ST_EMPTY]                = empty_s;
        stat_s[ST_FULL]                 = full_s;
        stat_s[ST_OVERRUN]              = overrun_r;
        stat_s[ST_PARITY]               = parity_err_r;
        stat_s[ST_FRAME]                = frame_err_r;
        stat_s[ST_CNT_LSB +: 8]         = 8'(count_s);
    end

    logic unused_bus_s;
    assign unused_bus_s = ^{bus.data_in[DATA_W-1:5], bus.data_in[1:0]};

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r    <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            overrun_r    <= set_ov_s | (overrun_r    & ~clr_s[0]);
            parity_err_r <= set_pe_s | (parity_err_r & ~clr_s[1]);
            frame_err_r  <= set_fe_s | (frame_err_r  & ~clr_s[2]);
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r <= '0;
        end else if (rd_data_s) begin
            if (empty_s) begin
                data_out_r <= '0;
            end else begin
                data_out_r <= DATA_W'({1'b1, head_s});
            end
        end else if (rd_stat_s) begin
            data_out_r <= stat_s;
        end else begin
            data_out_r <= data_out_r;
        end
    end

    assign bus.data_out = data_out_r;
endmodule
